// File: rtl/shared_mem_responder_if.sv
// Core/loader-facing bus of the shared memory responder: loader byte stream,
// fetch port, data port, and the tohost mailbox.
interface shared_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int LANES = DATA_WIDTH / 8;

    logic                  core_rst_n;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst_out;
    logic [DATA_WIDTH-1:0] mem_addr_in;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_we_in;
    logic [LANES-1:0]      mem_mask_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  tohost_valid;
    logic [DATA_WIDTH-1:0] tohost_data;

    modport slave (
        input  load_valid, load_byte, load_last, pc, mem_addr_in, mem_data_in,
               mem_we_in, mem_mask_in,
        output core_rst_n, load_ready, inst_out, mem_data_out, tohost_valid,
               tohost_data
    );

    modport master (
        output load_valid, load_byte, load_last, pc, mem_addr_in, mem_data_in,
               mem_we_in, mem_mask_in,
        input  core_rst_n, load_ready, inst_out, mem_data_out, tohost_valid,
               tohost_data
    );
endinterface

// File: rtl/shared_mem_responder.sv
// Unified I/D memory with boot loader, cycle counter and tohost mailbox.
// One byte-wide RAM per lane; fetch and data ports read combinationally.
module shared_mem_lane #(
    parameter int WORDS = 512,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_a,
    output logic [7:0]    rdata_b
);
    logic [7:0] ram [WORDS];

    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    assign rdata_a = ram[raddr_a];
    assign rdata_b = ram[raddr_b];
endmodule

module shared_mem_responder #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEM_SZ_IN_KB = 2,
    parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR  = 32'h8000_0000,
    parameter logic [DATA_WIDTH-1:0] CYCLE_ADDR   = 32'h8000_0004
) (
    input logic                  clk,
    input logic                  arst_n,
    shared_mem_responder_if.slave bus
);
    localparam int LANES     = DATA_WIDTH / 8;
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MEM_BYTES = MEM_SZ_IN_KB * 1024;
    localparam int MEM_WORDS = MEM_BYTES / 4;
    localparam int AW        = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [LW-1:0]         byte_cnt;
    logic [AW-1:0]         word_ptr;
    logic [DATA_WIDTH-1:0] cycle;
    logic                  th_valid;
    logic [DATA_WIDTH-1:0] th_data;

    logic                  load_fire, core_wr, tohost_hit;
    logic                  d_ram, d_tohost, d_cycle, i_ram;
    logic [AW-1:0]         d_idx, i_idx, waddr;
    logic [LANES-1:0]      lane_we;
    logic [LANES-1:0][7:0] lane_wdata, rdata_a, rdata_b;

    // Address decode ignores addr[1:0]; the core pre-aligns data and mask.
    assign d_ram    = bus.mem_addr_in < DATA_WIDTH'(MEM_BYTES);
    assign i_ram    = bus.pc < DATA_WIDTH'(MEM_BYTES);
    assign d_tohost = bus.mem_addr_in[DATA_WIDTH-1:2] == TOHOST_ADDR[DATA_WIDTH-1:2];
    assign d_cycle  = bus.mem_addr_in[DATA_WIDTH-1:2] == CYCLE_ADDR[DATA_WIDTH-1:2];
    assign d_idx    = bus.mem_addr_in[AW+1:2];
    assign i_idx    = bus.pc[AW+1:2];

    assign load_fire  = (state == LOAD) && bus.load_valid;
    assign core_wr    = (state == RUN) && bus.mem_we_in;
    assign tohost_hit = core_wr && d_tohost && (|bus.mem_mask_in);
    assign waddr      = (state == LOAD) ? word_ptr : d_idx;

    always_comb begin
        state_nxt      = state;
        bus.load_ready = 1'b0;
        bus.core_rst_n = 1'b0;
        case (state)
            LOAD: begin
                bus.load_ready = 1'b1;
                if (load_fire && bus.load_last) state_nxt = RUN;
            end
            RUN: begin
                bus.core_rst_n = 1'b1;
                if (tohost_hit) state_nxt = HALT;
            end
            HALT: state_nxt = HALT;
            default: state_nxt = LOAD;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        always_comb begin
            lane_we[i]    = 1'b0;
            lane_wdata[i] = bus.mem_data_in[i*8 +: 8];
            if (load_fire) begin
                lane_we[i]    = byte_cnt == LW'(i);
                lane_wdata[i] = bus.load_byte;
            end else if (core_wr && d_ram) begin
                lane_we[i] = bus.mem_mask_in[i];
            end
        end
    end

    shared_mem_lane #(.WORDS(MEM_WORDS)) u_lane [LANES-1:0] (
        .clk     (clk),
        .we      (lane_we),
        .waddr   (waddr),
        .wdata   (lane_wdata),
        .raddr_a (i_idx),
        .raddr_b (d_idx),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    assign bus.inst_out     = i_ram ? rdata_a : '0;
    assign bus.mem_data_out = d_ram ? rdata_b : (d_cycle ? cycle : '0);
    assign bus.tohost_valid = th_valid;
    assign bus.tohost_data  = th_data;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= LOAD;
            byte_cnt <= '0;
            word_ptr <= '0;
            cycle    <= '0;
            th_valid <= 1'b0;
            th_data  <= '0;
        end else begin
            state <= state_nxt;
            if (load_fire) begin
                byte_cnt <= byte_cnt + LW'(1);
                if (byte_cnt == LW'(LANES - 1)) word_ptr <= word_ptr + AW'(1);
            end
            // The halting cycle does not count, so the frozen value matches
            // what software could read just before the mailbox write.
            if (state == RUN && !tohost_hit) cycle <= cycle + DATA_WIDTH'(1);
            if (tohost_hit) begin
                th_valid <= 1'b1;
                th_data  <= bus.mem_data_in;
            end
        end
    end
endmodule

// File: tb/tb_shared_mem_responder.sv
// Directed bench for shared_mem_responder: boot load, masked writes, decode,
// cycle counter, mailbox halt, mid-load reset and loader pointer wrap.
`timescale 1ns/1ps
module tb_shared_mem_responder;
    localparam logic [31:0] TOHOST = 32'h8000_0000;
    localparam logic [31:0] CYC    = 32'h8000_0004;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    shared_mem_responder_if #(.DATA_WIDTH(32)) bus ();

    shared_mem_responder #(
        .DATA_WIDTH  (32),
        .MEM_SZ_IN_KB(2),
        .TOHOST_ADDR (TOHOST),
        .CYCLE_ADDR  (CYC)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b, input logic last);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus.mem_addr_in = a;
        bus.mem_we_in   = 1'b0;
        #1;
        check(tag, bus.mem_data_out, exp);
    endtask

    task automatic fetch(input logic [31:0] a, input string tag, input logic [31:0] exp);
        bus.pc = a;
        #1;
        check(tag, bus.inst_out, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.mem_addr_in = a;
        bus.mem_data_in = d;
        bus.mem_mask_in = m;
        bus.mem_we_in   = 1'b1;
        tick();
        bus.mem_we_in   = 1'b0;
        bus.mem_mask_in = 4'h0;
    endtask

    initial begin
        bus.load_valid  = 1'b0;
        bus.load_byte   = 8'h00;
        bus.load_last   = 1'b0;
        bus.pc          = '0;
        bus.mem_addr_in = '0;
        bus.mem_data_in = '0;
        bus.mem_we_in   = 1'b0;
        bus.mem_mask_in = 4'h0;

        // Reset state
        #3;
        check("rst_core_rst_n", 32'(bus.core_rst_n), 0);
        check("rst_load_ready", 32'(bus.load_ready), 1);
        check("rst_th_valid", 32'(bus.tohost_valid), 0);
        check("rst_th_data", bus.tohost_data, 0);
        check("rst_cycle", dut.cycle, 0);
        check("rst_byte_cnt", 32'(dut.byte_cnt), 0);
        check("rst_word_ptr", 32'(dut.word_ptr), 0);
        @(negedge clk);
        arst_n = 1'b1;

        // Boot load of word0, core released one cycle after the last byte
        load(8'h13, 1'b0);
        load(8'h05, 1'b0);
        load(8'h00, 1'b0);
        check("pre_last_core_rst_n", 32'(bus.core_rst_n), 0);
        load(8'h00, 1'b1);
        check("run_core_rst_n", 32'(bus.core_rst_n), 1);
        check("run_load_ready", 32'(bus.load_ready), 0);

        // RUN cycle 0
        rd(CYC, "cyc_first", 0);
        rd(32'h0, "word0", 32'h0000_0513);
        fetch(32'h0, "fetch0", 32'h0000_0513);
        wr(32'h4, 32'h1122_3344, 4'hF);

        // Cycle 1: masked write, same-cycle reads see old contents
        bus.mem_addr_in = 32'h4;
        bus.mem_data_in = 32'hAABB_CCDD;
        bus.mem_mask_in = 4'b0110;
        bus.mem_we_in   = 1'b1;
        #1;
        check("rdw_old_data", bus.mem_data_out, 32'h1122_3344);
        fetch(32'h4, "rdw_old_fetch", 32'h1122_3344);
        tick();
        bus.mem_we_in   = 1'b0;
        bus.mem_mask_in = 4'h0;

        // Cycle 2
        rd(32'h4, "mask_wr", 32'h11BB_CC44);
        fetch(32'h4, "mask_wr_fetch", 32'h11BB_CC44);
        bus.mem_mask_in = 4'hF;
        bus.mem_data_in = 32'h0;
        tick();
        bus.mem_mask_in = 4'h0;

        // Cycle 3: mask with we=0 had no effect
        rd(32'h4, "we0_nochange", 32'h11BB_CC44);
        wr(CYC, 32'hDEAD_BEEF, 4'hF);

        // Cycle 4: cycle counter write dropped, counter reads 4
        rd(CYC, "cyc_wr_dropped", 4);
        rd(32'h4000, "oob_read", 0);
        fetch(32'h4000, "oob_fetch", 0);
        rd(TOHOST, "tohost_read", 0);
        wr(32'h0, 32'hFFFF_FFFF, 4'h0);

        // Cycle 5: zero mask changed nothing; loader ignored in RUN
        rd(32'h0, "mask0_nochange", 32'h0000_0513);
        load(8'hFF, 1'b1);
        rd(32'h0, "loader_ignored", 32'h0000_0513);
        check("run_load_ready2", 32'(bus.load_ready), 0);

        // Advance to RUN cycle 10
        repeat (4) tick();
        rd(CYC, "cyc10", 10);
        check("pre_halt_th_valid", 32'(bus.tohost_valid), 0);
        wr(TOHOST, 32'h1, 4'hF);
        check("halt_th_valid", 32'(bus.tohost_valid), 1);
        check("halt_th_data", bus.tohost_data, 1);
        check("halt_core_rst_n", 32'(bus.core_rst_n), 0);
        check("halt_load_ready", 32'(bus.load_ready), 0);
        repeat (5) tick();
        rd(CYC, "cyc_frozen", 10);
        rd(32'h4, "halt_retain", 32'h11BB_CC44);
        check("halt_th_hold", 32'(bus.tohost_valid), 1);

        // Reset from HALT, then reset again mid-load
        arst_n = 1'b0;
        #1;
        check("rst_halt_th_valid", 32'(bus.tohost_valid), 0);
        check("rst_halt_state", 32'(dut.state), 0);
        arst_n = 1'b1;
        load(8'hAA, 1'b0);
        load(8'hBB, 1'b0);
        check("midload_byte_cnt", 32'(dut.byte_cnt), 2);
        arst_n = 1'b0;
        #1;
        check("midrst_byte_cnt", 32'(dut.byte_cnt), 0);
        check("midrst_word_ptr", 32'(dut.word_ptr), 0);
        check("midrst_state", 32'(dut.state), 0);
        check("midrst_load_ready", 32'(bus.load_ready), 1);
        arst_n = 1'b1;
        load(8'h78, 1'b0);
        load(8'h56, 1'b0);
        load(8'h34, 1'b0);
        load(8'h12, 1'b1);
        rd(32'h0, "reload_word0", 32'h1234_5678);

        // Loader pointer wrap: 4*512+1 bytes, byte i = i[7:0]^8'h5A
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
        for (int i = 0; i < 2048; i++) load(8'(i) ^ 8'h5A, 1'b0);
        check("wrap_word_ptr", 32'(dut.word_ptr), 0);
        check("wrap_byte_cnt", 32'(dut.byte_cnt), 0);
        load(8'h5A, 1'b1);
        rd(32'h0, "wrap_word0", 32'h5958_5B5A);
        rd(32'h4, "wrap_word1", 32'h5D5C_5F5E);
        rd(32'h7FC, "wrap_last_word", 32'hA5A4_A7A6);
        fetch(32'h7FC, "wrap_last_fetch", 32'hA5A4_A7A6);
        rd(32'h800, "ram_edge_read", 0);
        fetch(32'h800, "ram_edge_fetch", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
